// File: rtl/stream_upsizer_pkg.sv
// Shared types and helpers for the narrow-to-wide stream packer.
package stream_upsizer_pkg;

   typedef enum logic {
      FILL = 1'b0,
      EMIT = 1'b1
   } state_e;

   // Lane counter has to hold 0..ratio inclusive.
   function automatic int cnt_width(input int ratio);
      return $clog2(ratio + 1);
   endfunction

endpackage

// File: rtl/stream_upsizer.sv
// Packs Ratio narrow beats (first beat in the LSB lane) into one wide word.
// Define STREAM_UPSIZER_PARTIAL_EN to add flush_i / keep_o for partial words.
module stream_upsizer
   import stream_upsizer_pkg::*;
#(
   parameter int NarrowWidth = 8,
   parameter int Ratio       = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic [NarrowWidth-1:0]       data_i,
   output logic                         valid_o,
   input  logic                         ready_i,
`ifdef STREAM_UPSIZER_PARTIAL_EN
   input  logic                         flush_i,
   output logic [Ratio-1:0]             keep_o,
`endif
   output logic [NarrowWidth*Ratio-1:0] data_o
);

   localparam int              CntW    = cnt_width(Ratio);
   localparam int              WideW   = NarrowWidth * Ratio;
   localparam logic [CntW-1:0] CntFull = CntW'(Ratio);

   state_e               state_q;
   logic [CntW-1:0]      cnt_q;
   logic [WideW-1:0]     data_q;
   logic [CntW-1:0]      cnt_inc;
   logic [WideW-1:0]     word_fill;
   logic [WideW-1:0]     word_first;
   logic                 flush_go;

`ifdef STREAM_UPSIZER_PARTIAL_EN
   logic [Ratio-1:0]     keep_q;
   logic [Ratio-1:0]     keep_fill;
`endif

   // NOTE: every signal gets a default at the top of the block, so no path
   // through the lane loop can leave one unassigned and infer a latch.
   always_comb begin
      cnt_inc    = cnt_q + 1'b1;
      word_first = {{(WideW-NarrowWidth){1'b0}}, data_i};
      word_fill  = (cnt_q == '0) ? '0 : data_q;
`ifdef STREAM_UPSIZER_PARTIAL_EN
      keep_fill  = (cnt_q == '0) ? '0 : keep_q;
`endif
      for (int k = 0; k < Ratio; k++) begin
         if (cnt_q == CntW'(k)) begin
            word_fill[k*NarrowWidth +: NarrowWidth] = data_i;
`ifdef STREAM_UPSIZER_PARTIAL_EN
            keep_fill[k] = 1'b1;
`endif
         end
      end
`ifdef STREAM_UPSIZER_PARTIAL_EN
      // Lane count is taken after any beat accepted on the same edge.
      flush_go = flush_i && ((valid_i ? cnt_inc : cnt_q) != '0);
`else
      flush_go = 1'b0;
`endif
   end

   // NOTE: the word register is reset along with control because the output
   // must read as zero during reset; only flops driven with <= live here.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= FILL;
         cnt_q   <= '0;
         data_q  <= '0;
`ifdef STREAM_UPSIZER_PARTIAL_EN
         keep_q  <= '0;
`endif
      end else begin
         case (state_q)
            FILL: begin
               if (valid_i) begin
                  data_q <= word_fill;
                  cnt_q  <= cnt_inc;
`ifdef STREAM_UPSIZER_PARTIAL_EN
                  keep_q <= keep_fill;
`endif
               end
               if ((valid_i && cnt_inc == CntFull) || flush_go) begin
                  state_q <= EMIT;
               end
            end
            EMIT: begin
               if (ready_i) begin
                  state_q <= FILL;
                  if (valid_i) begin
                     // Back-to-back: the next word starts on the same edge.
                     data_q <= word_first;
                     cnt_q  <= CntW'(1);
`ifdef STREAM_UPSIZER_PARTIAL_EN
                     keep_q <= {{(Ratio-1){1'b0}}, 1'b1};
`endif
                  end else begin
                     cnt_q <= '0;
                  end
               end
            end
         endcase
      end
   end

   assign ready_o = (state_q == FILL) || ready_i;
   assign valid_o = (state_q == EMIT);
   assign data_o  = data_q;
`ifdef STREAM_UPSIZER_PARTIAL_EN
   assign keep_o  = keep_q;
`endif

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed bench for stream_upsizer (NarrowWidth=8, Ratio=4); partial-word
// steps run only when STREAM_UPSIZER_PARTIAL_EN is defined.
module tb_stream_upsizer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [7:0]  data_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] data_o;
`ifdef STREAM_UPSIZER_PARTIAL_EN
   logic        flush_i;
   logic [3:0]  keep_o;
`endif

   int checks   = 0;
   int failures = 0;

   stream_upsizer #(
      .NarrowWidth(8),
      .Ratio      (4)
   ) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .data_i (data_i),
      .valid_o(valid_o),
      .ready_i(ready_i),
`ifdef STREAM_UPSIZER_PARTIAL_EN
      .flush_i(flush_i),
      .keep_o (keep_o),
`endif
      .data_o (data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i   = 1'b1;
      valid_i = 1'b1;
      data_i  = 8'hEE;
      ready_i = 1'b1;
`ifdef STREAM_UPSIZER_PARTIAL_EN
      flush_i = 1'b1;
`endif
      // Reset with active handshakes: they must be ignored.
      tick();
      tick();
      check("rst_valid_o", valid_o, 0);
      check("rst_data_o", data_o, 0);
      check("rst_ready_o", ready_o, 1);
`ifdef STREAM_UPSIZER_PARTIAL_EN
      check("rst_keep_o", keep_o, 0);
      flush_i = 1'b0;
`endif
      rst_i   = 1'b0;
      valid_i = 1'b0;
      tick();
      check("post_rst_valid_o", valid_o, 0);
      check("post_rst_data_o", data_o, 0);

      // Four back-to-back beats, one-cycle output pulse.
      valid_i = 1'b1;
      data_i = 8'h11; check("w1_ready_b0", ready_o, 1); tick(); check("w1_valid_b0", valid_o, 0);
      data_i = 8'h22; check("w1_ready_b1", ready_o, 1); tick(); check("w1_valid_b1", valid_o, 0);
      data_i = 8'h33; check("w1_ready_b2", ready_o, 1); tick(); check("w1_valid_b2", valid_o, 0);
      data_i = 8'h44; check("w1_ready_b3", ready_o, 1); tick();
      valid_i = 1'b0;
      check("w1_valid", valid_o, 1);
      check("w1_data", data_o, 32'h44332211);
`ifdef STREAM_UPSIZER_PARTIAL_EN
      check("w1_keep", keep_o, 4'b1111);
`endif
      tick();
      check("w1_valid_drop", valid_o, 0);

      // Full word stalled for five cycles with a beat waiting upstream.
      ready_i = 1'b0;
      valid_i = 1'b1;
      data_i = 8'hA1; tick();
      data_i = 8'hA2; tick();
      data_i = 8'hA3; tick();
      data_i = 8'hA4; tick();
      data_i = 8'h99;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stall_valid_%0d", i), valid_o, 1);
         check($sformatf("stall_data_%0d", i), data_o, 32'hA4A3A2A1);
         check($sformatf("stall_ready_%0d", i), ready_o, 0);
         tick();
      end
      ready_i = 1'b1;
      data_i  = 8'h55;
      #1;
      check("release_ready_o", ready_o, 1);
      tick();
      check("release_valid_o", valid_o, 0);
      check("release_lane0", data_o, 32'h00000055);
      data_i = 8'h66; tick();
      data_i = 8'h77; tick();
      data_i = 8'h88; tick();
      valid_i = 1'b0;
      check("w2_valid", valid_o, 1);
      check("w2_data", data_o, 32'h88776655);
      tick();
      check("w2_valid_drop", valid_o, 0);

      // Eight continuous beats: two words, no stall.
      valid_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         data_i = 8'hB0 + 8'(i);
         #1;
         check($sformatf("stream_ready_%0d", i), ready_o, 1);
         tick();
         check($sformatf("stream_valid_%0d", i), valid_o, (i % 4 == 3) ? 1 : 0);
         if (i == 3) check("stream_word0", data_o, 32'hB3B2B1B0);
         if (i == 7) check("stream_word1", data_o, 32'hB7B6B5B4);
      end
      valid_i = 1'b0;
      tick();
      check("stream_valid_drop", valid_o, 0);

`ifdef STREAM_UPSIZER_PARTIAL_EN
      // Two beats then flush; a flush with nothing buffered is ignored.
      valid_i = 1'b1;
      data_i = 8'hAA; tick();
      data_i = 8'hBB; tick();
      valid_i = 1'b0;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("flush_valid", valid_o, 1);
      check("flush_data", data_o, 32'h0000BBAA);
      check("flush_keep", keep_o, 4'b0011);
      tick();
      check("flush_valid_drop", valid_o, 0);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("flush_empty_ignored", valid_o, 0);
`endif

      // Reset mid-word discards the partial word.
      valid_i = 1'b1;
      data_i = 8'hC1; tick();
      data_i = 8'hC2; tick();
      data_i = 8'hC3; tick();
      valid_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      check("midrst_valid_o", valid_o, 0);
      check("midrst_data_o", data_o, 0);
      check("midrst_ready_o", ready_o, 1);
      tick();
      rst_i   = 1'b0;
      valid_i = 1'b1;
      data_i = 8'h01; tick();
      data_i = 8'h02; tick();
      data_i = 8'h03; tick();
      check("midrst_no_early_valid", valid_o, 0);
      data_i = 8'h04; tick();
      valid_i = 1'b0;
      check("midrst_valid", valid_o, 1);
      check("midrst_data", data_o, 32'h04030201);
      tick();
      check("midrst_valid_drop", valid_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stream_upsizer.md
STREAM_UPSIZER -- requirements
Module: stream_upsizer

Interface
REQ-001 SHALL have parameter NarrowWidth, default 8: width in bits of one input beat.
REQ-002 SHALL have parameter Ratio, default 4: number of input beats packed into one output word (>=2).
REQ-003 SHALL have port clk_i  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port valid_i  input  1: the input beat is valid.
REQ-006 SHALL have port ready_o  output  1: the block accepts the input beat.
REQ-007 SHALL have port data_i  input  NarrowWidth: the input beat payload.
REQ-008 SHALL have port valid_o  output  1: the output word is valid.
REQ-009 SHALL have port ready_i  input  1: the consumer accepts the output word.
REQ-010 SHALL have port data_o  output  NarrowWidth*Ratio: the packed output word.
REQ-011 SHALL have port flush_i  input  1, present only with STREAM_UPSIZER_PARTIAL_EN: emit the partial word.
REQ-012 SHALL have port keep_o  output  Ratio, present only with STREAM_UPSIZER_PARTIAL_EN: one bit per filled lane.

Function
REQ-013 SHALL treat a transfer as complete only on a clock edge where valid and ready are both high (AXI rules) on that side.
REQ-014 SHALL write input beat k (k = 0..Ratio-1) of a word into lane k, i.e. data_o[k*NarrowWidth +: NarrowWidth]; the first beat goes in the LSB lane.
REQ-015 SHALL implement states FILL (0 < cnt < Ratio, or cnt = 0 idle) and EMIT (word complete, valid_o=1).
REQ-016 SHALL track filled lanes with a counter cnt of width $clog2(Ratio+1).
REQ-017 SHALL go FILL->EMIT on the edge that accepts beat Ratio-1; valid_o rises the next cycle (latency 1 cycle from the last input handshake).
REQ-018 SHALL drive ready_o = 1 in FILL and ready_o = ready_i in EMIT.
REQ-019 SHALL, in EMIT with ready_i=1 and valid_i=1, complete the output handshake, load the new beat into lane 0, set cnt=1 and stay in FILL (no bubble; sustained throughput of 1 input beat per cycle).
REQ-020 SHALL, in EMIT with ready_i=1 and valid_i=0, return to FILL with cnt=0.
REQ-021 SHALL hold data_o, keep_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-022 SHALL never drop valid_o without a completed output handshake.
REQ-023 SHALL clear unfilled lanes to zero whenever a new word starts.

Reset
REQ-024 SHALL, while rst_i is high, hold state FILL, cnt=0, valid_o=0, data_o=0 and keep_o=0, with ready_o=1; handshakes during reset SHALL be ignored.
REQ-025 SHALL discard any partially filled or pending word on reset asserted mid-operation.

Configuration
REQ-026 SHALL, with STREAM_UPSIZER_PARTIAL_EN defined, enter EMIT on an edge where flush_i=1 and 0<cnt<Ratio (counted after any same-edge input handshake); keep_o SHALL mark the filled lanes.
REQ-027 SHALL, with STREAM_UPSIZER_PARTIAL_EN defined, ignore flush_i when cnt=0 or when already in EMIT.
REQ-028 SHALL, with STREAM_UPSIZER_PARTIAL_EN defined, drive keep_o all-ones for full words.
REQ-029 SHALL, without STREAM_UPSIZER_PARTIAL_EN, omit flush_i and keep_o and emit only full words.

Structure
REQ-030 SHALL place the state enum (FILL, EMIT) and a count-width constant function in package stream_upsizer_pkg.
REQ-031 SHALL be one flat module; no sub-module is required.

Verification (NarrowWidth=8, Ratio=4)
REQ-032 SHALL cover: beats 0x11,0x22,0x33,0x44 back-to-back with ready_i=1 -> one cycle later valid_o=1 and data_o=0x44332211 for exactly 1 cycle.
REQ-033 SHALL cover: full word held with ready_i=0 for 5 cycles -> data_o stable, ready_o=0; then ready_i=1 with valid_i=1 and data 0x55 -> output handshake, and the next word lane 0 = 0x55.
REQ-034 SHALL cover: 8 continuous beats with ready_i=1 -> two words, ready_o=1 every cycle.
REQ-035 SHALL cover (PARTIAL_EN): beats 0xAA,0xBB then flush_i -> data_o=0x0000BBAA, keep_o=4'b0011.
REQ-036 SHALL cover: rst_i pulsed after 3 beats -> valid_o=0; the next 4 beats 0x01..0x04 give data_o=0x04030201.
